// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and defaults for the FIR filter datapath
package fir_pkg;

    localparam int FIR_ACC_W          = 32;
    localparam int FIR_SAMPLE_W       = 16;
    localparam int FIR_GAIN_SHIFT     = 7;
    localparam int FIR_FRAME_LEN      = 256;
    localparam int FIR_OUT_FIFO_DEPTH = 4;

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int fir_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word-fall-through data+last buffer with registered input ready
module axis_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     push_last,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     head_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     in_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W:0]    mem_q [DEPTH];
    logic [W:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en, rd_en;

    assign wr_en = push & in_ready_q;
    assign rd_en = pop & (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d    = count_q + CW'(wr_en) - CW'(rd_en);
        // Ready looks ahead at the post-edge occupancy so it is a clean flop output.
        in_ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q][W-1:0];
    assign head_last = mem_q[rd_ptr_q][W];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = in_ready_q;

endmodule

// File: rtl/fir_output_requant.sv
// rtl/fir_output_requant.sv - rounding shift, saturation, frame tagging and output buffering of FIR sums
module fir_output_requant
    import fir_pkg::*;
#(
    parameter int IN_W       = FIR_ACC_W,
    parameter int OUT_W      = FIR_SAMPLE_W,
    parameter int SHIFT      = FIR_GAIN_SHIFT,
    parameter int FIFO_DEPTH = FIR_OUT_FIFO_DEPTH,
    parameter int FRAME_LEN  = FIR_FRAME_LEN
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             s_axis_valid,
    input  logic [IN_W-1:0]  s_axis_data,
    output logic             s_axis_ready,
    output logic             m_axis_valid,
    output logic [OUT_W-1:0] m_axis_data,
    output logic             m_axis_last,
    input  logic             m_axis_ready,
    input  logic             sat_clr,
    output logic [15:0]      sat_count
);

    localparam int FW     = fir_cnt_w(FRAME_LEN);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RND  = (SHIFT > 0) ? ((IN_W + 1)'(1) << RND_SH) : '0;
    localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W:0] ext, rnd_sum, shifted;
    logic                 sat_hi, sat_lo, clamp;
    logic [OUT_W-1:0]     q_data;
    logic                 accept, pop, q_last;
    logic [15:0]          sat_count_q, sat_count_d;
    logic [FW-1:0]        frame_q, frame_d;
    logic                 fifo_full, fifo_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    assign ext     = signed'({s_axis_data[IN_W-1], s_axis_data});
    assign rnd_sum = ext + RND;
    assign shifted = rnd_sum >>> SHIFT;
    assign sat_hi  = (shifted > MAXV);
    assign sat_lo  = (shifted < MINV);
    assign clamp   = sat_hi | sat_lo;

    always_comb begin
        q_data = shifted[OUT_W-1:0];
        if (sat_hi) begin
            q_data = MAXV[OUT_W-1:0];
        end else if (sat_lo) begin
            q_data = MINV[OUT_W-1:0];
        end
    end

    assign accept = s_axis_valid & s_axis_ready & ~fifo_full;
    assign q_last = (frame_q == FW'(FRAME_LEN - 1));

    always_comb begin
        sat_count_d = sat_count_q;
        frame_d     = frame_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (accept && clamp && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
        if (accept) begin
            frame_d = q_last ? '0 : frame_q + 1'b1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            sat_count_q <= '0;
            frame_q     <= '0;
        end else begin
            sat_count_q <= sat_count_d;
            frame_q     <= frame_d;
        end
    end

    assign m_axis_valid = (fifo_count != '0);
    assign pop          = m_axis_valid & m_axis_ready;
    assign s_axis_ready = fifo_ready;
    assign sat_count    = sat_count_q;

    axis_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .push        (accept),
        .push_data   (q_data),
        .push_last   (q_last),
        .pop         (pop),
        .head_data   (m_axis_data),
        .head_last   (m_axis_last),
        .count       (fifo_count),
        .full        (fifo_full),
        .in_ready    (fifo_ready)
    );

endmodule

// File: tb/tb_fir_output_requant.sv
// tb/tb_fir_output_requant.sv - directed and randomized checks of fir_output_requant against an arithmetic model
module tb_fir_output_requant;

    localparam int FL = 4;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        s_axis_valid;
    logic [31:0] s_axis_data;
    logic        s_axis_ready;
    logic        m_axis_valid;
    logic [15:0] m_axis_data;
    logic        m_axis_last;
    logic        m_axis_ready;
    logic        sat_clr;
    logic [15:0] sat_count;

    always #5 axi_clk = ~axi_clk;

    fir_output_requant #(.FRAME_LEN(FL)) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .sat_clr      (sat_clr),
        .sat_count    (sat_count)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   frame_m = 0;
    int   sat_m = 0;
    int   out_idx = 0;
    int   last_mask = 0;
    bit   acc;
    bit   rand_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Floor division of (x + 64) by 128, then clamp to the signed 16-bit range.
    function automatic longint requant(input logic [31:0] x, output bit clamped);
        longint v, n, r;
        v = longint'($signed(x));
        n = v + 64;
        r = (n >= 0) ? n / 128 : -((-n + 127) / 128);
        clamped = 1'b0;
        if (r > 32767) begin
            r = 32767;
            clamped = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            clamped = 1'b1;
        end
        return r;
    endfunction

    task automatic cycle();
        exp_t   e;
        bit     cl;
        longint r;
        @(negedge axi_clk);
        acc = s_axis_valid && s_axis_ready;
        if (m_axis_valid && m_axis_ready) begin
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL spurious_output observed=%0h expected=none", m_axis_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", m_axis_data, e.d);
                chk("out_last", m_axis_last, e.l);
                if (m_axis_last) last_mask |= (1 << out_idx);
                out_idx++;
            end
        end
        if (acc) begin
            r   = requant(s_axis_data, cl);
            e.d = r[15:0];
            e.l = (frame_m == FL - 1);
            q.push_back(e);
            frame_m = (frame_m + 1) % FL;
        end
        if (sat_clr) sat_m = 0;
        else if (acc && cl && sat_m < 65535) sat_m++;
        @(posedge axi_clk);
        #1;
        if (rand_rdy) m_axis_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) cycle();
        tests++;
        assert (acc) else begin
            fails++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted data=%0h", d);
        end
        s_axis_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rdy     = 0;
        m_axis_ready = 1'b1;
        for (int i = 0; i < 50 && (q.size() != 0 || m_axis_valid); i++) cycle();
        chk("drain_model_empty", q.size(), 0);
        chk("drain_valid_low", m_axis_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        axi_reset_n  = 1'b0;
        s_axis_valid = 1'b0;
        #1;
        chk("rst_valid", m_axis_valid, 1'b0);
        chk("rst_data", m_axis_data, 16'h0000);
        chk("rst_last", m_axis_last, 1'b0);
        chk("rst_sat", sat_count, 16'h0000);
        chk("rst_ready", s_axis_ready, 1'b0);
        q.delete();
        frame_m = 0;
        sat_m   = 0;
        @(posedge axi_clk);
        #1;
        axi_reset_n = 1'b1;
        @(posedge axi_clk);
        #1;
        chk("ready_after_release", s_axis_ready, 1'b1);
    endtask

    initial begin
        axi_reset_n  = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        m_axis_ready = 1'b1;
        sat_clr      = 1'b0;
        repeat (3) @(posedge axi_clk);
        #1;
        chk("init_valid", m_axis_valid, 1'b0);
        chk("init_data", m_axis_data, 16'h0000);
        chk("init_last", m_axis_last, 1'b0);
        chk("init_sat", sat_count, 16'h0000);
        chk("init_ready", s_axis_ready, 1'b0);
        axi_reset_n = 1'b1;
        @(posedge axi_clk);
        #1;
        chk("ready_first_edge", s_axis_ready, 1'b1);

        send(32'h0000_0080);
        chk("t1_valid", m_axis_valid, 1'b1);
        chk("t1_data", m_axis_data, 16'h0001);
        chk("t1_sat", sat_count, 16'h0000);

        send(32'h0000_00C0);  chk("t2_c0", m_axis_data, 16'h0002);
        send(32'hFFFF_FF40);  chk("t2_neg", m_axis_data, 16'hFFFF);
        send(32'h0000_003F);  chk("t2_3f", m_axis_data, 16'h0000);
        send(32'hFFFF_FFC0);  chk("t2_negc0", m_axis_data, 16'h0000);

        send(32'h7FFF_FFFF);  chk("t3_pos", m_axis_data, 16'h7FFF);
        chk("t3_sat1", sat_count, 16'd1);
        send(32'h8000_0000);  chk("t3_neg", m_axis_data, 16'h8000);
        chk("t3_sat2", sat_count, 16'd2);
        sat_clr = 1'b1;
        send(32'h7FFF_FFFF);
        sat_clr = 1'b0;
        chk("t3_clr_wins", sat_count, 16'd0);
        drain();

        m_axis_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(32'(k) << 7);
        chk("t4_full_ready", s_axis_ready, 1'b0);
        s_axis_valid = 1'b1;
        s_axis_data  = 32'(5) << 7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_hold_data", m_axis_data, 16'h0001);
            chk("t4_hold_valid", m_axis_valid, 1'b1);
            chk("t4_hold_ready", s_axis_ready, 1'b0);
        end
        m_axis_ready = 1'b1;
        cycle();
        chk("t4_ready_back", s_axis_ready, 1'b1);
        send(32'(5) << 7);
        send(32'(6) << 7);
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) send($urandom);
            else send($urandom_range(0, 32'h000F_FFFF) ^ (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0));
        end
        drain();
        chk("rand_sat", sat_count, 32'(sat_m));

        pulse_reset();
        out_idx   = 0;
        last_mask = 0;
        rand_rdy  = 1;
        for (int k = 1; k <= 9; k++) send(32'(k) << 7);
        drain();
        chk("t5_count", out_idx, 9);
        chk("t5_last_mask", last_mask, 32'h88);

        for (int k = 0; k < 3; k++) send(32'h0000_0100);
        drain();
        m_axis_ready = 1'b0;
        send(32'h7FFF_FFFF);
        send(32'h0000_0100);
        send(32'h0000_0200);
        chk("t6_buffered_valid", m_axis_valid, 1'b1);
        chk("t6_pre_sat", sat_count, 32'(sat_m));
        pulse_reset();
        m_axis_ready = 1'b1;
        out_idx   = 0;
        last_mask = 0;
        for (int k = 1; k <= 4; k++) send(32'(k) << 7);
        drain();
        chk("t6_count", out_idx, 4);
        chk("t6_last_mask", last_mask, 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
